dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the extended CPU's load/store path. It accepts one word-wide read or write request at a time from the CPU-side initiator over a req/ack handshake. It inserts a configurable number of wait states, performs the access on an internal word-addressed RAM with byte enables, and returns a single-cycle acknowledge with read data and an error flag.

## Interface
- `ADDR_W`, default 10: word-address width; RAM depth is 2^ADDR_W 32-bit words.
- `WAIT`, default 2: wait cycles inserted between acceptance and response; legal range 0..15.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; latched with `req`.
- `addr`  in  32  byte address; latched with `req`.
- `wdata`  in  32  write data; latched with `req`.
- `be`  in  4  byte enables for writes, `be[i]` enables `wdata[8i+7:8i]`; latched with `req`.
- `ack`  out  1  high for exactly one cycle (RESP) per accepted request.
- `rdata`  out  32  registered read data, valid while `ack` = 1 for reads.
- `err`  out  1  qualifies `ack`; 1 = request rejected.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `busy` = 0, `ack` = 0.
  - WAIT: a 4-bit counter runs down.
  - RESP: `ack` = 1.
- IDLE, `req` = 1 at an edge:
  - Latch `we`, `addr`, `wdata` and `be`.
  - If `WAIT` > 0, go to WAIT with counter = `WAIT`−1.
  - If `WAIT` = 0, go directly to RESP and perform the access on that edge.
- IDLE, `req` = 0: stay in IDLE.
- WAIT: the counter decrements each edge. At the edge where counter = 0, go to RESP and perform the access on that edge.
- RESP: go to IDLE unconditionally on the next edge.
- Access rules, evaluated on the latched request:
  - Error condition: `addr[1:0]` ≠ 0, or `addr[31:ADDR_W+2]` ≠ 0.
  - On error: no RAM access and `err` = 1. An erroring read loads `rdata` = 0; an erroring write leaves the RAM untouched.
  - Write without error: update only the bytes enabled by `be`. `be` = 0 is a legal no-op write with `err` = 0. `rdata` keeps its previous value.
  - Read without error: `rdata` = RAM[`addr[ADDR_W+1:2]`] as a full word; `be` is ignored.
- `err` is valid only with `ack`; it is 0 outside RESP.
- Once a request is latched:
  - Input changes during WAIT/RESP are ignored.
  - Dropping `req` before `ack` does not abort the transaction.
- RAM contents are not reset; a read before the first write to that word returns an undefined value.

## Timing
- Reset (`rst_n` = 0, asynchronous) forces:
  - state = IDLE, counter = 0;
  - `ack` = 0, `err` = 0, `rdata` = 0, `busy` = 0.
- Reset asserted in WAIT abandons the pending request. A write that has not reached its RESP-entry edge is never committed.
- Latency: request accepted at edge E0 → `ack` high in the cycle following edge E0+`WAIT`. This is 1 cycle for `WAIT` = 0 and 3 cycles for `WAIT` = 2.
- Initiator rule: the initiator updates `req` at the edge that ends RESP. If `req` is still 1 in the following IDLE cycle, that is a new request.
- Minimum issue spacing is therefore `WAIT`+2 cycles; back-to-back requests are accepted with exactly one IDLE cycle between RESP cycles.
- `busy` rises in the cycle after acceptance and falls in the cycle after RESP.
- `rdata` changes only on the RESP-entry edge of a read, or on reset.

## Test plan
- **Reset values.** Assert `rst_n` = 0 mid-WAIT of a write of 0xDEADBEEF to 0x10 → `ack`, `err`, `busy` and `rdata` go 0 immediately, with no clock edge needed. A subsequent read of 0x10 must not return 0xDEADBEEF, unless the bench pre-wrote that value.
- **Write then read, `WAIT` = 2.**
  - Write 0x12345678 to 0x40 with `be` = 4'hF → `ack` exactly 1 cycle, 3 cycles after acceptance, `err` = 0.
  - Read 0x40 → `rdata` = 0x12345678 in the `ack` cycle.
- **Byte enables.** After the full write above, write 0xAABBCCDD to 0x40 with `be` = 4'b0101; read back → 0x12BB56DD. A write with `be` = 0 → `ack`, `err` = 0, word unchanged.
- **Errors.**
  - Read 0x41 → `ack` with `err` = 1 and `rdata` = 0.
  - Write to 0x1000 with `ADDR_W` = 10 → `err` = 1. A follow-up read of 0x0 returns its prior contents.
- **Back-to-back with held `req`, `WAIT` = 0.** Hold `req` = 1 for three reads of 0x0/0x4/0x8 → `ack` pattern 1,0,1,0,1 with the correct data each time. Dropping `req` right after acceptance still yields exactly one `ack`.
- **Input changes.** Change `addr` and `wdata` during WAIT → the RAM update and `rdata` reflect the latched values only.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one req/ack transaction at a time, a fixed number of
// wait states, then a one-cycle acknowledge with read data and an error flag.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam int         DEPTH    = 1 << ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic              do_access;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    logic [31:0]       mem [DEPTH];

    // With zero wait states the access happens on the accepting edge itself,
    // so the operands come straight from the ports instead of the latches.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state == ST_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
        acc_idx = acc_addr[ADDR_W+1:2];
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_access  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT == 0) begin
                        state_next = ST_RESP;
                        do_access  = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    do_access  = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (state == ST_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    // err is only ever set on the edge entering RESP, so it self-clears after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            err <= do_access ? acc_err : 1'b0;
            if (do_access && !acc_we) begin
                rdata <= acc_err ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // The RAM has no reset; the rst_n term keeps a zero-wait request from writing while held in reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ack  = (state == ST_RESP);
    assign busy = (state != ST_IDLE);

endmodule
